panda_alu_arbiter: RTL

PANDA_ALU_ARBITER -- requirements
Module: panda_alu_arbiter

---
 rtl/panda_alu_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/panda_alu_arbiter.sv
// panda_alu_arbiter: two-port arbiter in front of a single combinational ALU, one operation in flight.
package panda_pkg;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
      ALU_SRA, ALU_SLT, ALU_SLTU, ALU_EQ, ALU_NE, ALU_GE, ALU_GEU
   } alu_operator_e;
endpackage

module panda_alu_arbiter
   import panda_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req0_valid_i,
   output logic          req0_ready_o,
   input  alu_operator_e req0_operator_i,
   input  logic [31:0]   req0_operand_a_i,
   input  logic [31:0]   req0_operand_b_i,
   input  logic          req1_valid_i,
   output logic          req1_ready_o,
   input  alu_operator_e req1_operator_i,
   input  logic [31:0]   req1_operand_a_i,
   input  logic [31:0]   req1_operand_b_i,
   output logic          rsp0_valid_o,
   output logic [31:0]   rsp0_result_o,
   input  logic          rsp0_ready_i,
   output logic          rsp1_valid_o,
   output logic [31:0]   rsp1_result_o,
   input  logic          rsp1_ready_i,
   output alu_operator_e alu_operator_o,
   output logic [31:0]   alu_operand_a_o,
   output logic [31:0]   alu_operand_b_o,
   input  logic [31:0]   alu_result_i
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]    state_q;
   alu_operator_e op_q;
   logic [31:0]   a_q, b_q, res_q;
   logic          gnt_q, last_q;
   logic          any_req, sel, accept;

   // sel picks port 1 when set; only meaningful while some port is requesting
   always_comb begin
      any_req = req0_valid_i | req1_valid_i;
      sel     = FIXED_PRIO ? !req0_valid_i
              : (req0_valid_i && req1_valid_i) ? !last_q : req1_valid_i;
      accept  = (state_q == IDLE) && any_req && !rst_i;
   end

   assign req0_ready_o    = accept && !sel;
   assign req1_ready_o    = accept && sel;
   assign rsp0_valid_o    = (state_q == RESP) && !gnt_q;
   assign rsp1_valid_o    = (state_q == RESP) && gnt_q;
   assign rsp0_result_o   = rsp0_valid_o ? res_q : '0;
   assign rsp1_result_o   = rsp1_valid_o ? res_q : '0;
   assign alu_operator_o  = op_q;
   assign alu_operand_a_o = a_q;
   assign alu_operand_b_o = b_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         op_q    <= ALU_ADD;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: if (any_req) begin
               op_q    <= sel ? req1_operator_i : req0_operator_i;
               a_q     <= sel ? req1_operand_a_i : req0_operand_a_i;
               b_q     <= sel ? req1_operand_b_i : req0_operand_b_i;
               gnt_q   <= sel;
               last_q  <= sel;
               state_q <= EXEC;
            end
            EXEC: begin
               res_q   <= alu_result_i;
               state_q <= RESP;
            end
            RESP: if (gnt_q ? rsp1_ready_i : rsp0_ready_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
